// File: rtl/store_pkg.sv
// Shared types for the store path: opcode encodings, lane count and the buffered store entry.
package store_pkg;

    localparam int unsigned LANES       = 4;
    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned DATA_W      = 32;

    typedef enum logic [2:0] {
        OP_SB  = 3'b000,
        OP_SH  = 3'b001,
        OP_SW  = 3'b010,
        OP_SWL = 3'b011,
        OP_SWR = 3'b100
    } st_op_t;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      data;
        logic [LANES-1:0]       be;
    } st_entry_t;

endpackage

// File: rtl/store_format.sv
// Combinational store formatter: op/address/rt into word address, byte enables and lane-aligned data.
module store_format
    import store_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        legal_c,
    output st_entry_t   entry_c
);

    logic [1:0] o;

    assign o = addr[1:0];

    // Little-endian: the byte at offset o lives in lane o.
    always_comb begin
        legal_c      = 1'b1;
        entry_c.addr = addr[31:2];
        entry_c.be   = '0;
        entry_c.data = '0;
        case (st_op_t'(op))
            OP_SB: begin
                entry_c.be   = 4'b0001 << o;
                entry_c.data = {24'h0, data[7:0]} << {o, 3'b000};
            end
            OP_SH: begin
                legal_c      = ~o[0];
                entry_c.be   = 4'b0011 << o;
                entry_c.data = {16'h0, data[15:0]} << {o, 3'b000};
            end
            OP_SW: begin
                legal_c      = (o == 2'b00);
                entry_c.be   = 4'b1111;
                entry_c.data = data;
            end
            OP_SWL: begin
                entry_c.be   = 4'b1111 >> (2'd3 - o);
                entry_c.data = data >> {2'd3 - o, 3'b000};
            end
            OP_SWR: begin
                entry_c.be   = 4'b1111 << o;
                entry_c.data = data << {o, 3'b000};
            end
            default: legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: formats store requests, buffers them in a FIFO and drains them as Avalon-style writes.
module store_unit
    import store_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_data,
    output logic                     req_err,
    output logic [31:0]              avm_address,
    output logic                     avm_write,
    output logic [31:0]              avm_writedata,
    output logic [3:0]               avm_byteenable,
    input  logic                     avm_waitrequest,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t           state, state_nxt;
    st_entry_t        fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             rdy_en;
    logic             fmt_legal_c;
    st_entry_t        fmt_entry_c;
    st_entry_t        load_entry_c;
    logic             accept_c, push_c, pop_c, load_c, load_next_c, write_nxt_c;

    store_format u_format (
        .op      (req_op),
        .addr    (req_addr),
        .data    (req_data),
        .legal_c (fmt_legal_c),
        .entry_c (fmt_entry_c)
    );

    // rdy_en keeps req_ready low while reset is asserted.
    assign req_ready    = rdy_en && (count < CNT_W'(DEPTH));
    assign accept_c     = req_valid && req_ready;
    assign push_c       = accept_c && fmt_legal_c;
    assign busy         = (count != '0) || avm_write;
    assign load_entry_c = load_next_c ? fifo_mem[rd_ptr + PTR_W'(1)] : fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // The head entry stays queued until its write completes, so count includes the in-flight write.
    always_comb begin
        state_nxt   = state;
        pop_c       = 1'b0;
        load_c      = 1'b0;
        load_next_c = 1'b0;
        write_nxt_c = avm_write;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    load_c      = 1'b1;
                    write_nxt_c = 1'b1;
                    state_nxt   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    pop_c = 1'b1;
                    if (count >= CNT_W'(2)) begin
                        load_c      = 1'b1;
                        load_next_c = 1'b1;
                    end else begin
                        write_nxt_c = 1'b0;
                        state_nxt   = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= fmt_entry_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            rdy_en         <= 1'b0;
            req_err        <= 1'b0;
            done           <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            rdy_en    <= 1'b1;
            req_err   <= accept_c && !fmt_legal_c;
            done      <= pop_c;
            avm_write <= write_nxt_c;
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (load_c) begin
                avm_address    <= {load_entry_c.addr, 2'b00};
                avm_writedata  <= load_entry_c.data;
                avm_byteenable <= load_entry_c.be;
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a scoreboard of expected bus writes.
module tb_store_unit;
    import store_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_err;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic        done;
    logic        busy;
    logic [2:0]  count;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   wr_seen = 0;

    logic        stall_prev = 1'b0;
    logic [31:0] held_addr, held_data;
    logic [3:0]  held_be;

    store_unit #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_err         (req_err),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .done            (done),
        .busy            (busy),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference formatter built lane by lane from the source byte each lane receives.
    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] rt, output logic legal, output exp_t e);
        int o;
        o = int'(addr[1:0]);
        legal = 1'b1;
        e.addr = {addr[31:2], 2'b00};
        e.be = 4'h0;
        e.data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            logic en;
            int src;
            en = 1'b0;
            src = 0;
            case (op)
                3'd0: begin en = (k == o); src = 0; end
                3'd1: begin en = (k == o) || (k == o + 1); src = k - o; legal = (o % 2 == 0); end
                3'd2: begin en = 1'b1; src = k; legal = (o == 0); end
                3'd3: begin en = (k <= o); src = k + 3 - o; end
                3'd4: begin en = (k >= o); src = k - o; end
                default: legal = 1'b0;
            endcase
            if (en) begin
                e.be[k] = 1'b1;
                e.data[8*k +: 8] = rt[8*src +: 8];
            end
        end
    endfunction

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        logic legal;
        exp_t e;
        logic rdy;
        logic ok;
        ok = 1'b0;
        model(op, addr, data, legal, e);
        if (legal) sb.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        for (int n = 0; n < 40; n++) begin
            rdy = req_ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        chk("send_accepted", 32'(ok), 32'h1);
    endtask

    // Single store into an idle unit with no stall: write in t+2, done in t+3.
    task automatic single(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
        send(op, addr, data);
        chk({tag, "_count_t1"}, 32'(count), 32'h1);
        chk({tag, "_write_t1"}, 32'(avm_write), 32'h0);
        step();
        chk({tag, "_write_t2"}, 32'(avm_write), 32'h1);
        chk({tag, "_addr"}, avm_address, exp_addr);
        chk({tag, "_be"}, 32'(avm_byteenable), 32'(exp_be));
        chk({tag, "_data"}, avm_writedata, exp_data);
        chk({tag, "_done_t2"}, 32'(done), 32'h0);
        step();
        chk({tag, "_done_t3"}, 32'(done), 32'h1);
        chk({tag, "_write_t3"}, 32'(avm_write), 32'h0);
    endtask

    // Bus monitor: scoreboard compare on completion, stability check while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (done) done_seen++;
            if (stall_prev) begin
                chk("stall_write", 32'(avm_write), 32'h1);
                chk("stall_addr", avm_address, held_addr);
                chk("stall_data", avm_writedata, held_data);
                chk("stall_be", 32'(avm_byteenable), 32'(held_be));
            end
            if (avm_write && !avm_waitrequest) begin
                exp_t e;
                wr_seen++;
                chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_addr", avm_address, e.addr);
                    chk("sb_data", avm_writedata, e.data);
                    chk("sb_be", 32'(avm_byteenable), 32'(e.be));
                end
            end
            stall_prev = avm_write && avm_waitrequest;
            held_addr  = avm_address;
            held_data  = avm_writedata;
            held_be    = avm_byteenable;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 3'b000;
        req_addr = 32'h0;
        req_data = 32'h0;
        avm_waitrequest = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_write", 32'(avm_write), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(req_ready), 32'h1);

        single("sb", OP_SB, 32'h0000_1003, 32'h1122_3344, 32'h0000_1000, 4'b1000, 32'h4400_0000);
        single("swl", OP_SWL, 32'h0000_2001, 32'hAABB_CCDD, 32'h0000_2000, 4'b0011, 32'h0000_AABB);
        single("swr", OP_SWR, 32'h0000_2001, 32'hAABB_CCDD, 32'h0000_2000, 4'b1110, 32'hBBCC_DD00);

        // Rejected requests: misaligned SH, then an undefined opcode.
        send(OP_SH, 32'h0000_3001, 32'h1234_5678);
        chk("sh_mis_err", 32'(req_err), 32'h1);
        chk("sh_mis_count", 32'(count), 32'h0);
        step();
        chk("sh_mis_err_clear", 32'(req_err), 32'h0);
        chk("sh_mis_nowrite", 32'(avm_write), 32'h0);
        send(3'b111, 32'h0000_3000, 32'h1234_5678);
        chk("op7_err", 32'(req_err), 32'h1);
        chk("op7_count", 32'(count), 32'h0);
        step();
        chk("op7_nowrite", 32'(avm_write), 32'h0);
        chk("op7_busy", 32'(busy), 32'h0);

        single("sw", OP_SW, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF);

        // Five back-to-back SW with a stalled bus.
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) send(OP_SW, 32'h0000_5000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
        chk("full_count", 32'(count), 32'h4);
        chk("full_ready", 32'(req_ready), 32'h0);
        chk("full_write", 32'(avm_write), 32'h1);
        begin
            logic legal;
            exp_t e;
            model(OP_SW, 32'h0000_5010, 32'hC0DE_0004, legal, e);
            sb.push_back(e);
        end
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h0000_5010;
        req_data  = 32'hC0DE_0004;
        step();
        chk("held_count", 32'(count), 32'h4);
        chk("held_ready", 32'(req_ready), 32'h0);
        chk("held_addr", avm_address, 32'h0000_5000);
        avm_waitrequest = 1'b0;
        for (int i = 1; i < 5; i++) begin
            logic [2:0] exp_cnt;
            step();
            if (i == 2) req_valid = 1'b0;
            exp_cnt = (i <= 2) ? 3'd3 : 3'(5 - i);
            chk("b2b_write", 32'(avm_write), 32'h1);
            chk("b2b_done", 32'(done), 32'h1);
            chk("b2b_addr", avm_address, 32'h0000_5000 + 32'(4 * i));
            chk("b2b_count", 32'(count), 32'(exp_cnt));
        end
        step();
        chk("b2b_last_done", 32'(done), 32'h1);
        chk("b2b_idle_write", 32'(avm_write), 32'h0);
        chk("b2b_idle_count", 32'(count), 32'h0);
        step();

        // Asynchronous reset during a stalled write with two entries queued.
        avm_waitrequest = 1'b1;
        send(OP_SW, 32'h0000_6000, 32'h6666_0000);
        send(OP_SW, 32'h0000_6004, 32'h6666_0004);
        chk("pre_rst_count", 32'(count), 32'h2);
        chk("pre_rst_write", 32'(avm_write), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_write", 32'(avm_write), 32'h0);
        chk("arst_addr", avm_address, 32'h0);
        chk("arst_data", avm_writedata, 32'h0);
        chk("arst_be", 32'(avm_byteenable), 32'h0);
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_ready", 32'(req_ready), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_err", 32'(req_err), 32'h0);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        avm_waitrequest = 1'b0;
        step();
        chk("rel_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("rel_count", 32'(count), 32'h0);
            chk("rel_nowrite", 32'(avm_write), 32'h0);
            step();
        end

        chk("done_vs_writes", 32'(done_seen), 32'(wr_seen));
        chk("total_writes", 32'(wr_seen), 32'd9);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
